// File: rtl/four_port_write_arbiter_pkg.sv
// Shared types and sizing for the four-port write-arbitrated lookup table.
package four_port_pkg;

  localparam int NUM_PORTS  = 4;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  typedef logic [1:0] port_idx_t;

endpackage

// File: rtl/four_port_write_arbiter_rr_arbiter4.sv
// Combinational 4-way round-robin pick: searches ptr+1, ptr+2, ... mod 4.
module rr_arbiter4
  import four_port_pkg::*;
(
  input  logic [NUM_PORTS-1:0] i_req,
  input  port_idx_t            i_ptr,
  output logic [NUM_PORTS-1:0] o_grant,
  output logic                 o_valid,
  output port_idx_t            o_idx
);

  port_idx_t w_cand;

  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    o_idx   = i_ptr;
    w_cand  = i_ptr;
    // Offset 4 wraps back to the last winner, so it is considered last.
    for (int k = 1; k <= NUM_PORTS; k++) begin
      w_cand = port_idx_t'(i_ptr + port_idx_t'(k));
      if (!o_valid && i_req[w_cand]) begin
        o_valid         = 1'b1;
        o_idx           = w_cand;
        o_grant[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/four_port_write_arbiter.sv
// Shared lookup table with four combinational read ports and four
// round-robin arbitrated write ports; identity-initialised after reset.
module four_port_write_arbiter
  import four_port_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
)
(
  input  logic              clk,
  input  logic              reset,
  output logic              Ready,
  input  logic [ADDR_W-1:0] AddressBus0,
  input  logic [ADDR_W-1:0] AddressBus1,
  input  logic [ADDR_W-1:0] AddressBus2,
  input  logic [ADDR_W-1:0] AddressBus3,
  output logic [DATA_W-1:0] DataBus0,
  output logic [DATA_W-1:0] DataBus1,
  output logic [DATA_W-1:0] DataBus2,
  output logic [DATA_W-1:0] DataBus3,
  input  logic              WriteReq0,
  input  logic              WriteReq1,
  input  logic              WriteReq2,
  input  logic              WriteReq3,
  input  logic [ADDR_W-1:0] WriteAddr0,
  input  logic [ADDR_W-1:0] WriteAddr1,
  input  logic [ADDR_W-1:0] WriteAddr2,
  input  logic [ADDR_W-1:0] WriteAddr3,
  input  logic [DATA_W-1:0] WriteData0,
  input  logic [DATA_W-1:0] WriteData1,
  input  logic [DATA_W-1:0] WriteData2,
  input  logic [DATA_W-1:0] WriteData3,
  output logic              WriteAck0,
  output logic              WriteAck1,
  output logic              WriteAck2,
  output logic              WriteAck3
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0]    r_mem [DEPTH];
  state_t               r_state;
  state_t               w_state_nxt;
  logic [ADDR_W-1:0]    r_init_cnt;
  logic                 r_ready;
  logic [NUM_PORTS-1:0] r_ack;
  port_idx_t            r_ptr;

  logic [NUM_PORTS-1:0] w_req;
  logic [NUM_PORTS-1:0] w_elig;
  logic [NUM_PORTS-1:0] w_grant;
  logic [NUM_PORTS-1:0] w_ack_nxt;
  logic                 w_gnt_vld;
  port_idx_t            w_gnt_idx;
  logic [ADDR_W-1:0]    w_waddr_arr [NUM_PORTS];
  logic [DATA_W-1:0]    w_wdata_arr [NUM_PORTS];
  logic                 w_we;
  logic [ADDR_W-1:0]    w_we_addr;
  logic [DATA_W-1:0]    w_we_data;
  logic                 w_init_last;

  assign w_req          = {WriteReq3, WriteReq2, WriteReq1, WriteReq0};
  assign w_waddr_arr[0] = WriteAddr0;
  assign w_waddr_arr[1] = WriteAddr1;
  assign w_waddr_arr[2] = WriteAddr2;
  assign w_waddr_arr[3] = WriteAddr3;
  assign w_wdata_arr[0] = WriteData0;
  assign w_wdata_arr[1] = WriteData1;
  assign w_wdata_arr[2] = WriteData2;
  assign w_wdata_arr[3] = WriteData3;

  // A port whose ack is high is still holding the request we just committed.
  assign w_elig = w_req & ~r_ack;

  rr_arbiter4 u_arb (
    .i_req   (w_elig),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_valid (w_gnt_vld),
    .o_idx   (w_gnt_idx)
  );

  assign w_init_last = (r_init_cnt == {ADDR_W{1'b1}});

  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = '0;
    w_we        = 1'b0;
    w_we_addr   = r_init_cnt;
    w_we_data   = DATA_W'(r_init_cnt);
    case (r_state)
      ST_INIT: begin
        w_we = 1'b1;
        if (w_init_last) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_gnt_vld) begin
          w_we      = 1'b1;
          w_we_addr = w_waddr_arr[w_gnt_idx];
          w_we_data = w_wdata_arr[w_gnt_idx];
          w_ack_nxt = w_grant;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
      r_ready    <= 1'b0;
      r_ack      <= '0;
      r_ptr      <= 2'd3;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= w_ack_nxt;
      if (r_state == ST_INIT) begin
        r_init_cnt <= r_init_cnt + 1'b1;
        if (w_init_last) r_ready <= 1'b1;
      end
      if ((r_state == ST_RUN) && w_gnt_vld) r_ptr <= w_gnt_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && w_we) r_mem[w_we_addr] <= w_we_data;
  end

  assign Ready     = r_ready;
  assign WriteAck0 = r_ack[0];
  assign WriteAck1 = r_ack[1];
  assign WriteAck2 = r_ack[2];
  assign WriteAck3 = r_ack[3];

  assign DataBus0 = r_mem[AddressBus0];
  assign DataBus1 = r_mem[AddressBus1];
  assign DataBus2 = r_mem[AddressBus2];
  assign DataBus3 = r_mem[AddressBus3];

endmodule

// File: tb/tb_four_port_write_arbiter.sv
// Bench for four_port_write_arbiter: directed scenarios plus random traffic
// checked every cycle against a behavioural table/arbiter model.
module tb_four_port_write_arbiter;

  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  wire           Ready;
  logic [AW-1:0] raddr [4];
  wire  [DW-1:0] rd [4];
  logic [3:0]    req;
  logic [AW-1:0] waddr [4];
  logic [DW-1:0] wdata [4];
  wire  [3:0]    ack;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  four_port_write_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .Ready       (Ready),
    .AddressBus0 (raddr[0]),
    .AddressBus1 (raddr[1]),
    .AddressBus2 (raddr[2]),
    .AddressBus3 (raddr[3]),
    .DataBus0    (rd[0]),
    .DataBus1    (rd[1]),
    .DataBus2    (rd[2]),
    .DataBus3    (rd[3]),
    .WriteReq0   (req[0]),
    .WriteReq1   (req[1]),
    .WriteReq2   (req[2]),
    .WriteReq3   (req[3]),
    .WriteAddr0  (waddr[0]),
    .WriteAddr1  (waddr[1]),
    .WriteAddr2  (waddr[2]),
    .WriteAddr3  (waddr[3]),
    .WriteData0  (wdata[0]),
    .WriteData1  (wdata[1]),
    .WriteData2  (wdata[2]),
    .WriteData3  (wdata[3]),
    .WriteAck0   (ack[0]),
    .WriteAck1   (ack[1]),
    .WriteAck2   (ack[2]),
    .WriteAck3   (ack[3])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: table contents, known-ness, sweep position, grant history.
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_known [DEPTH];
  bit            m_run;
  bit            m_ready;
  int            m_cnt;
  bit   [3:0]    m_ack;
  int            m_last;
  int            m_w;
  bit            chk_en = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      m_run   = 1'b0;
      m_cnt   = 0;
      m_ready = 1'b0;
      m_ack   = '0;
      m_last  = 3;
      chk_en  = 1'b1;
    end else if (!m_run) begin
      m_mem[m_cnt]   = DW'(m_cnt);
      m_known[m_cnt] = 1'b1;
      if (m_cnt == DEPTH - 1) begin
        m_run   = 1'b1;
        m_ready = 1'b1;
      end
      m_cnt = (m_cnt + 1) % DEPTH;
      m_ack = '0;
    end else begin
      m_w = -1;
      for (int k = 1; k <= 4; k++) begin
        if (m_w < 0 && req[(m_last + k) % 4] && !m_ack[(m_last + k) % 4])
          m_w = (m_last + k) % 4;
      end
      m_ack = '0;
      if (m_w >= 0) begin
        m_mem[waddr[m_w]]   = wdata[m_w];
        m_known[waddr[m_w]] = 1'b1;
        m_ack[m_w]          = 1'b1;
        m_last              = m_w;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("Ready", Ready, m_ready);
      for (int n = 0; n < 4; n++) begin
        chk($sformatf("WriteAck%0d", n), ack[n], m_ack[n]);
        if (m_known[raddr[n]])
          chk($sformatf("DataBus%0d@%0h", n, raddr[n]), rd[n], m_mem[raddr[n]]);
      end
    end
  end

  bit auto_drop = 1'b1;

  task automatic step(output logic [3:0] a);
    @(posedge clk);
    #1;
    a = ack;
    if (auto_drop)
      for (int n = 0; n < 4; n++) if (a[n]) req[n] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] a;
    logic [3:0] prev;
    int         edges;
    bit         early;
    int         wcnt [4];

    req = '0;
    for (int n = 0; n < 4; n++) begin
      raddr[n] = '0;
      waddr[n] = '0;
      wdata[n] = '0;
      wcnt[n]  = 0;
    end

    // Power-up reset and first sweep
    repeat (3) step(a);
    reset = 1'b1;
    edges = 0;
    while (Ready !== 1'b1 && edges < 400) begin
      step(a);
      edges++;
    end
    chk("ready_edges", edges, 256);
    raddr[0] = 8'h00; raddr[1] = 8'h11; raddr[2] = 8'h80; raddr[3] = 8'hFF;
    #1;
    chk("id_00", rd[0], 8'h00);
    chk("id_11", rd[1], 8'h11);
    chk("id_80", rd[2], 8'h80);
    chk("id_FF", rd[3], 8'hFF);

    // All four ports to one address in the same cycle
    for (int n = 0; n < 4; n++) begin
      req[n]   = 1'b1;
      waddr[n] = 8'h20;
      wdata[n] = DW'(n + 1);
    end
    raddr[0] = 8'h20;
    for (int i = 0; i < 4; i++) begin
      step(a);
      chk($sformatf("burst_grant%0d", i), a, 4'b0001 << i);
    end
    step(a);
    chk("burst_idle", a, 4'b0000);
    chk("burst_final", rd[0], 8'h04);
    chk("model_20", m_mem[8'h20], 8'h04);

    // Single write from port 2
    req[2] = 1'b1; waddr[2] = 8'h10; wdata[2] = 8'hA5;
    raddr[0] = 8'h10;
    step(a);
    chk("single_ack", a, 4'b0100);
    chk("single_rd", rd[0], 8'hA5);
    step(a);
    chk("single_ack_once", a, 4'b0000);

    // Ports 1 and 3 re-requesting continuously
    auto_drop = 1'b0;
    req[1] = 1'b1; waddr[1] = 8'h30; wdata[1] = 8'h11;
    req[3] = 1'b1; waddr[3] = 8'h31; wdata[3] = 8'h33;
    prev = 4'b0010;
    for (int i = 0; i < 8; i++) begin
      step(a);
      chk($sformatf("alt%0d", i), a, (prev == 4'b0010) ? 4'b1000 : 4'b0010);
      prev = a;
      if (a[1]) wdata[1] = wdata[1] + 8'h1;
      if (a[3]) wdata[3] = wdata[3] + 8'h1;
    end
    req = '0;
    auto_drop = 1'b1;
    step(a);

    // Request raised while the sweep is still running
    reset = 1'b0;
    repeat (3) step(a);
    reset = 1'b1;
    repeat (10) step(a);
    req[0] = 1'b1; waddr[0] = 8'h33; wdata[0] = 8'h5A;
    edges = 10;
    early = 1'b0;
    while (Ready !== 1'b1 && edges < 400) begin
      step(a);
      edges++;
      if (a[0]) early = 1'b1;
    end
    chk("init_no_early_ack", early, 1'b0);
    chk("init_ready_edges", edges, 256);
    chk("init_ack_at_ready", ack[0], 1'b0);
    step(a);
    chk("init_first_grant", a, 4'b0001);
    raddr[2] = 8'h33;
    repeat (3) step(a);
    chk("init_persist", rd[2], 8'h5A);

    // Reset dropped while port 1 is pending
    req[2] = 1'b1; waddr[2] = 8'h10; wdata[2] = 8'hA5;
    step(a);
    chk("mid_write_ack", a, 4'b0100);
    raddr[0] = 8'h10; raddr[1] = 8'h40;
    req[1] = 1'b1; waddr[1] = 8'h40; wdata[1] = 8'hEE;
    reset = 1'b0;
    step(a);
    chk("mid_acks_low", a, 4'b0000);
    chk("mid_ready_low", Ready, 1'b0);
    chk("mid_lost", rd[1], 8'h40);
    chk("mid_kept", rd[0], 8'hA5);
    req[1] = 1'b0;
    repeat (2) step(a);
    reset = 1'b1;
    edges = 0;
    while (Ready !== 1'b1 && edges < 400) begin
      step(a);
      edges++;
    end
    chk("resweep_edges", edges, 256);
    chk("resweep_10", rd[0], 8'h10);
    chk("resweep_40", rd[1], 8'h40);
    chk("model_10", m_mem[8'h10], 8'h10);

    // Random traffic on a small address window to provoke collisions
    auto_drop = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      for (int n = 0; n < 4; n++) raddr[n] = AW'($urandom_range(0, 31));
      step(a);
      for (int n = 0; n < 4; n++) begin
        if (req[n]) wcnt[n]++;
        if (a[n]) begin
          checks++;
          if (wcnt[n] > 5) begin
            errors++;
            $display("FAIL wait%0d: granted after %0d edges, limit 5", n, wcnt[n]);
          end
          wcnt[n] = 0;
          if ($urandom_range(0, 1) == 1) begin
            waddr[n] = AW'($urandom_range(0, 31));
            wdata[n] = DW'($urandom);
          end else begin
            req[n] = 1'b0;
          end
        end else if (!req[n] && $urandom_range(0, 2) == 0) begin
          req[n]   = 1'b1;
          waddr[n] = AW'($urandom_range(0, 31));
          wdata[n] = DW'($urandom);
        end
      end
    end
    req = '0;
    repeat (3) step(a);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
